vga_syncmod: RTL and testbench
==============================

VGA_SYNCMOD -- requirements
Module: vga_syncmod

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- SA, 10'd96, horizontal sync width in pixels
- SB, 10'd48, horizontal back porch
- SC, 10'd640, horizontal active width
- SD, 10'd16, horizontal front porch
- SE, 10'd800, horizontal total
- SO, 10'd2, vertical sync height in lines
- SP, 10'd33, vertical back porch
- SQ, 10'd480, vertical active height
- SR, 10'd10, vertical front porch
- SS, 10'd525, vertical total
- DIV, 3'd1, CLOCK cycles per pixel; legal range 1..4
- SYNC_DELAY, 2'd2, CLOCK-cycle delay applied to HSYNC/VSYNC to match the 2-stage downstream pixel pipeline; legal range 0..3
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLOCK, input, 1, single system clock; all logic on its rising edge
- RESET, input, 1, synchronous, active-high reset
- EN, input, 1, run enable
- HSYNC, output, 1, horizontal sync, active-low, delayed by SYNC_DELAY
- VSYNC, output, 1, vertical sync, active-low, delayed by SYNC_DELAY
- oAddr, output, 20, {hcnt[9:0], vcnt[9:0]}, undelayed; feeds the display-control stage
- oActive, output, 1, high while hcnt is in [SA+SB, SA+SB+SC-1] and vcnt is in [SO+SP, SO+SP+SQ-1]; undelayed
- oFrameStart, output, 1, one-CLOCK pulse when the counters wrap to (0,0)

Function
REQ-003 A divider counter dcnt SHALL run 0..DIV-1 while EN=1; the pixel tick SHALL be asserted when dcnt==DIV-1 (every cycle when DIV=1).
REQ-004 On each pixel tick, hcnt SHALL increment; at SE-1 it SHALL wrap to 0.
REQ-005 vcnt SHALL increment on the tick where hcnt wraps, and SHALL wrap to 0 after SS-1.
REQ-006 hcnt and vcnt SHALL be 10-bit registers, and oAddr SHALL update in the same cycle as the counter registers.
REQ-007 The raw syncs SHALL be defined as: hs_raw = (hcnt >= SA); vs_raw = (vcnt >= SO).
- Sync is low for hcnt 0..SA-1 and vcnt 0..SO-1.
REQ-008 HSYNC and VSYNC SHALL equal hs_raw and vs_raw delayed by exactly SYNC_DELAY CLOCK cycles through a shift register; SYNC_DELAY=0 SHALL give combinational pass-through of the registered counters.
REQ-009 oActive SHALL be combinational from hcnt and vcnt and SHALL NOT be delayed.
REQ-010 oFrameStart SHALL be registered and high for exactly one CLOCK in the cycle after the tick that wraps both hcnt (SE-1 to 0) and vcnt (SS-1 to 0).
REQ-011 While EN=0, the block SHALL behave as follows:
- dcnt, hcnt and vcnt hold at 0
- the raw syncs are forced high
- the delay line keeps shifting, so HSYNC/VSYNC go high SYNC_DELAY cycles later
- oFrameStart is 0
REQ-012 On EN 0 to 1, counting SHALL begin at (0,0), with the first tick after DIV cycles.
- No oFrameStart pulse is issued for this restart.
REQ-013 If EN drops mid-frame, the counters SHALL clear to (0,0) on the next CLOCK.
REQ-014 A line SHALL be exactly SE*DIV CLOCK cycles and a frame exactly SE*SS*DIV CLOCK cycles, with no extra cycle at either wrap.

Reset
REQ-015 When RESET=1 at a CLOCK edge, the following SHALL clear regardless of EN:
- dcnt, hcnt and vcnt to 0
- every delay-line stage to 1, so HSYNC=1 and VSYNC=1
- oFrameStart to 0
REQ-016 While in reset, oAddr SHALL be 20'd0 and oActive SHALL be 0.
REQ-017 Reset asserted mid-frame SHALL take effect on that edge.
- Counting restarts per REQ-012 on the first edge with RESET=0 and EN=1.

Verification
REQ-018 Reset then EN=1, DIV=1, SYNC_DELAY=2 -> oAddr counts 20'h00000, 20'h00400, ...; HSYNC goes low 2 cycles after EN; HSYNC low for 96 cycles, period 800 cycles.
REQ-019 Run one full frame -> VSYNC low for 1600 cycles; oFrameStart pulses once, 420000 cycles after the first tick; oActive high for 307200 cycles per frame.
REQ-020 Check the oActive boundaries -> oActive first rises at hcnt=144, vcnt=35 and last falls after hcnt=783, vcnt=514.
REQ-021 Set DIV=2 -> each oAddr value holds for 2 cycles; line = 1600 cycles; HSYNC low for 192 cycles.
REQ-022 Drive EN=0 at hcnt=300, vcnt=100 for 5 cycles, then EN=1 -> oAddr=0 on the next edge; HSYNC=1 after 2 cycles; no oFrameStart pulse; restart from (0,0).
REQ-023 Assert RESET=1 for 1 cycle mid-line with EN=1 -> oAddr=0, HSYNC=VSYNC=1 immediately; counting resumes the next cycle.

Source files
------------

// File: rtl/vga_syncmod.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical counters,
// active-low syncs through a configurable delay line, and a frame-start strobe.
module vga_syncmod #(
  parameter logic [9:0] SA         = 10'd96,
  parameter logic [9:0] SB         = 10'd48,
  parameter logic [9:0] SC         = 10'd640,
  parameter logic [9:0] SD         = 10'd16,
  parameter logic [9:0] SE         = 10'd800,
  parameter logic [9:0] SO         = 10'd2,
  parameter logic [9:0] SP         = 10'd33,
  parameter logic [9:0] SQ         = 10'd480,
  parameter logic [9:0] SR         = 10'd10,
  parameter logic [9:0] SS         = 10'd525,
  parameter logic [2:0] DIV        = 3'd1,
  parameter logic [1:0] SYNC_DELAY = 2'd2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        EN,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [19:0] oAddr,
  output logic        oActive,
  output logic        oFrameStart
);

  localparam int DLY = int'(SYNC_DELAY);

  if (DIV < 3'd1 || DIV > 3'd4) begin : g_bad_div
    $error("vga_syncmod: DIV must be 1..4");
  end
  if (SA + SB + SC + SD != SE) begin : g_bad_htotal
    $error("vga_syncmod: horizontal timing does not sum to SE");
  end
  if (SO + SP + SQ + SR != SS) begin : g_bad_vtotal
    $error("vga_syncmod: vertical timing does not sum to SS");
  end

  logic [2:0] dcnt_q, dcnt_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       frame_q, frame_d;
  logic       tick, h_wrap, v_wrap;
  logic       hs_raw, vs_raw;

  assign tick   = EN && (dcnt_q == DIV - 3'd1);
  assign h_wrap = (hcnt_q == SE - 10'd1);
  assign v_wrap = (vcnt_q == SS - 10'd1);

  // Dropping EN parks everything at (0,0) so a restart begins a clean frame.
  always_comb begin
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    frame_d = 1'b0;
    if (!EN) begin
      dcnt_d = 3'd0;
      hcnt_d = 10'd0;
      vcnt_d = 10'd0;
    end else begin
      dcnt_d = tick ? 3'd0 : dcnt_q + 3'd1;
      if (tick) begin
        hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
        if (h_wrap) begin
          vcnt_d  = v_wrap ? 10'd0 : vcnt_q + 10'd1;
          frame_d = v_wrap;
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      dcnt_q  <= 3'd0;
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      frame_q <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
    end
  end

  assign hs_raw = (RESET || !EN) ? 1'b1 : (hcnt_q >= SA);
  assign vs_raw = (RESET || !EN) ? 1'b1 : (vcnt_q >= SO);

  // Tap 0 is the raw sync; tap DLY is what leaves the block (DLY=0 is a wire).
  logic [DLY:0] hs_tap, vs_tap;
  assign hs_tap[0] = hs_raw;
  assign vs_tap[0] = vs_raw;

  for (genvar gi = 0; gi < DLY; gi++) begin : g_stage
    logic hs_q, vs_q;
    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        hs_q <= 1'b1;
        vs_q <= 1'b1;
      end else begin
        hs_q <= hs_tap[gi];
        vs_q <= vs_tap[gi];
      end
    end
    assign hs_tap[gi+1] = hs_q;
    assign vs_tap[gi+1] = vs_q;
  end

  assign HSYNC = hs_tap[DLY];
  assign VSYNC = vs_tap[DLY];

  assign oAddr   = RESET ? 20'd0 : {hcnt_q, vcnt_q};
  assign oActive = !RESET
                && (hcnt_q >= SA + SB) && (hcnt_q <= SA + SB + SC - 10'd1)
                && (vcnt_q >= SO + SP) && (vcnt_q <= SO + SP + SQ - 10'd1);
  assign oFrameStart = frame_q;

endmodule

// File: tb/tb_vga_syncmod.sv
// Bench for vga_syncmod: two instances (DIV=1/delay 2 and DIV=2/delay 0) on a
// reduced raster, checked every cycle against an arithmetic timing model.
module tb_vga_syncmod;

  localparam int P_SA = 4, P_SB = 3, P_SC = 10, P_SD = 3, P_SE = 20;
  localparam int P_SO = 2, P_SP = 2, P_SQ = 5,  P_SR = 1, P_SS = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic        hs1, vs1, act1, fs1, hs2, vs2, act2, fs2;
  logic [19:0] a1, a2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_syncmod #(
    .SA(10'(P_SA)), .SB(10'(P_SB)), .SC(10'(P_SC)), .SD(10'(P_SD)), .SE(10'(P_SE)),
    .SO(10'(P_SO)), .SP(10'(P_SP)), .SQ(10'(P_SQ)), .SR(10'(P_SR)), .SS(10'(P_SS)),
    .DIV(3'd1), .SYNC_DELAY(2'd2)
  ) u_dut1 (
    .CLOCK(clk), .RESET(rst), .EN(en), .HSYNC(hs1), .VSYNC(vs1),
    .oAddr(a1), .oActive(act1), .oFrameStart(fs1)
  );

  vga_syncmod #(
    .SA(10'(P_SA)), .SB(10'(P_SB)), .SC(10'(P_SC)), .SD(10'(P_SD)), .SE(10'(P_SE)),
    .SO(10'(P_SO)), .SP(10'(P_SP)), .SQ(10'(P_SQ)), .SR(10'(P_SR)), .SS(10'(P_SS)),
    .DIV(3'd2), .SYNC_DELAY(2'd0)
  ) u_dut2 (
    .CLOCK(clk), .RESET(rst), .EN(en), .HSYNC(hs2), .VSYNC(vs2),
    .oAddr(a2), .oActive(act2), .oFrameStart(fs2)
  );

  // Model: t_m counts enabled clocks since the last clear; position is t/DIV on the raster.
  int unsigned t_m = 0;
  logic [3:0]  hh1 = 4'hF;
  logic [3:0]  hv1 = 4'hF;

  function automatic int unsigned mh(int unsigned t, int unsigned div);
    return (t / div) % P_SE;
  endfunction

  function automatic int unsigned mv(int unsigned t, int unsigned div);
    return (t / div / P_SE) % P_SS;
  endfunction

  function automatic logic raw_h(int unsigned t, int unsigned div, logic e, logic r);
    return (r || !e) ? 1'b1 : (mh(t, div) >= P_SA);
  endfunction

  function automatic logic raw_v(int unsigned t, int unsigned div, logic e, logic r);
    return (r || !e) ? 1'b1 : (mv(t, div) >= P_SO);
  endfunction

  function automatic logic [23:0] model_vec(int unsigned t, int unsigned div,
                                            logic hsx, logic vsx, logic r);
    int unsigned h, v;
    logic act, fs;
    logic [19:0] addr;
    h    = mh(t, div);
    v    = mv(t, div);
    act  = !r && h >= P_SA + P_SB && h < P_SA + P_SB + P_SC
              && v >= P_SO + P_SP && v < P_SO + P_SP + P_SQ;
    fs   = (t != 0) && (t % (P_SE * P_SS * div) == 0);
    addr = r ? 20'd0 : {10'(h), 10'(v)};
    return {addr, act, hsx, vsx, fs};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t_m <= 0;
      hh1 <= 4'hF;
      hv1 <= 4'hF;
    end else begin
      t_m <= en ? t_m + 1 : 0;
      hh1 <= {hh1[2:0], raw_h(t_m, 1, en, rst)};
      hv1 <= {hv1[2:0], raw_v(t_m, 1, en, rst)};
    end
  end

  wire [23:0] got1 = {a1, act1, hs1, vs1, fs1};
  wire [23:0] got2 = {a2, act2, hs2, vs2, fs2};
  wire [23:0] exp1 = model_vec(t_m, 1, hh1[1], hv1[1], rst);
  wire [23:0] exp2 = model_vec(t_m, 2, raw_h(t_m, 2, en, rst), raw_v(t_m, 2, en, rst), rst);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rst = 1'b1;
      en  = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (got1 !== {20'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reset_dut1 cyc=%0d got=%h exp=%h", i, got1, {20'd0, 4'b0110});
      end
      total++;
      if (got2 !== {20'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reset_dut2 cyc=%0d got=%h exp=%h", i, got2, {20'd0, 4'b0110});
      end
      $display("reset cyc=%0d dut1=%h dut2=%h", i, got1, got2);
      next_cycle();
    end
    rst = 1'b0;
    en  = 1'b0;
    next_cycle();
  endtask

  task automatic test_frame();
    int run_h1 = 0, run_h2 = 0, run_v1 = 0;
    int n_act1 = 0, n_fs1 = 0, n_fs2 = 0;
    int first_fs1 = -1, first_lo1 = -1, last_fall1 = -1;
    logic prev_hs1 = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 810; i++) begin
      @(negedge clk);
      total++;
      if (got1 !== exp1) begin
        bad++;
        $display("FAIL frame_dut1 cyc=%0d got=%h exp=%h", i, got1, exp1);
      end
      total++;
      if (got2 !== exp2) begin
        bad++;
        $display("FAIL frame_dut2 cyc=%0d got=%h exp=%h", i, got2, exp2);
      end
      if (hs1 === 1'b0 && prev_hs1 === 1'b1) begin
        if (first_lo1 < 0) first_lo1 = i;
        if (last_fall1 >= 0) begin
          total++;
          if (i - last_fall1 != P_SE) begin
            bad++;
            $display("FAIL hsync_period got=%0d exp=%0d", i - last_fall1, P_SE);
          end
        end
        last_fall1 = i;
      end
      prev_hs1 = hs1;
      if (hs1 === 1'b0) run_h1++;
      else if (run_h1 != 0) begin
        total++;
        if (run_h1 != P_SA) begin
          bad++;
          $display("FAIL hsync1_low got=%0d exp=%0d", run_h1, P_SA);
        end
        run_h1 = 0;
      end
      if (hs2 === 1'b0) run_h2++;
      else if (run_h2 != 0) begin
        total++;
        if (run_h2 != 2 * P_SA) begin
          bad++;
          $display("FAIL hsync2_low got=%0d exp=%0d", run_h2, 2 * P_SA);
        end
        run_h2 = 0;
      end
      if (vs1 === 1'b0) run_v1++;
      else if (run_v1 != 0) begin
        total++;
        if (run_v1 != P_SO * P_SE) begin
          bad++;
          $display("FAIL vsync1_low got=%0d exp=%0d", run_v1, P_SO * P_SE);
        end
        run_v1 = 0;
      end
      if (act1 === 1'b1) n_act1++;
      if (fs1 === 1'b1) begin
        n_fs1++;
        if (first_fs1 < 0) first_fs1 = i;
      end
      if (fs2 === 1'b1) n_fs2++;
      if (i % 100 == 0) $display("frame cyc=%0d dut1=%h dut2=%h", i, got1, got2);
      next_cycle();
    end
    total++;
    if (first_lo1 != 2) begin
      bad++;
      $display("FAIL hsync_first_low got=%0d exp=%0d", first_lo1, 2);
    end
    total++;
    if (first_fs1 != P_SE * P_SS) begin
      bad++;
      $display("FAIL framestart_time got=%0d exp=%0d", first_fs1, P_SE * P_SS);
    end
    total++;
    if (n_fs1 != 4 || n_fs2 != 2) begin
      bad++;
      $display("FAIL framestart_count got=%0d/%0d exp=4/2", n_fs1, n_fs2);
    end
    total++;
    if (n_act1 != 4 * P_SC * P_SQ) begin
      bad++;
      $display("FAIL active_count got=%0d exp=%0d", n_act1, 4 * P_SC * P_SQ);
    end
    $display("frame summary act1=%0d fs1=%0d fs2=%0d first_fs1=%0d", n_act1, n_fs1, n_fs2, first_fs1);
  endtask

  task automatic test_en_drop();
    int n1, d;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    n1 = $urandom_range(30, 380);
    d  = $urandom_range(1, 8);
    for (int i = 0; i < n1 + d + 60; i++) begin
      en = !(i >= n1 && i < n1 + d);
      @(negedge clk);
      total++;
      if (got1 !== exp1) begin
        bad++;
        $display("FAIL endrop_dut1 cyc=%0d got=%h exp=%h", i, got1, exp1);
      end
      total++;
      if (got2 !== exp2) begin
        bad++;
        $display("FAIL endrop_dut2 cyc=%0d got=%h exp=%h", i, got2, exp2);
      end
      if (i == n1 + 1) begin
        total++;
        if (a1 !== 20'd0 || a2 !== 20'd0) begin
          bad++;
          $display("FAIL endrop_clear got=%h/%h exp=0", a1, a2);
        end
      end
      if (i == n1 + 2) begin
        total++;
        if (hs1 !== 1'b1) begin
          bad++;
          $display("FAIL endrop_hsync got=%b exp=1", hs1);
        end
      end
      if (i >= n1 - 1 && i <= n1 + d + 1)
        $display("endrop cyc=%0d en=%b dut1=%h dut2=%h", i, en, got1, got2);
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    int n1;
    en = 1'b1;
    n1 = $urandom_range(30, 380);
    for (int i = 0; i < n1 + 40; i++) begin
      rst = (i == n1);
      @(negedge clk);
      total++;
      if (got1 !== exp1) begin
        bad++;
        $display("FAIL rstmid_dut1 cyc=%0d got=%h exp=%h", i, got1, exp1);
      end
      total++;
      if (got2 !== exp2) begin
        bad++;
        $display("FAIL rstmid_dut2 cyc=%0d got=%h exp=%h", i, got2, exp2);
      end
      if (i == n1 + 1) begin
        total++;
        if ({a1, hs1, vs1} !== {20'd0, 2'b11}) begin
          bad++;
          $display("FAIL rstmid_clear got=%h exp=%h", {a1, hs1, vs1}, {20'd0, 2'b11});
        end
      end
      if (i == n1 + 2) begin
        total++;
        if (a1 !== {10'd1, 10'd0}) begin
          bad++;
          $display("FAIL rstmid_resume got=%h exp=%h", a1, {10'd1, 10'd0});
        end
      end
      if (i >= n1 - 1 && i <= n1 + 2)
        $display("rstmid cyc=%0d rst=%b dut1=%h dut2=%h", i, rst, got1, got2);
      next_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      en  = ($urandom_range(0, 31) != 0);
      @(negedge clk);
      total++;
      if (got1 !== exp1) begin
        bad++;
        $display("FAIL random_dut1 cyc=%0d got=%h exp=%h", i, got1, exp1);
      end
      total++;
      if (got2 !== exp2) begin
        bad++;
        $display("FAIL random_dut2 cyc=%0d got=%h exp=%h", i, got2, exp2);
      end
      if (i % 100 == 0) $display("random cyc=%0d rst=%b en=%b dut1=%h dut2=%h", i, rst, en, got1, got2);
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
